// File: rtl/oserdes_burst_scheduler.sv
// Burst scheduler feeding an 8:1 OSERDES2 word stream from a small pattern table.
// Optional: define OSERDES_BURST_SCHEDULER_RETRIGGER_EN to let requests restart a running burst.
module oserdes_burst_scheduler #(
    parameter int WIDTH        = 8,
    parameter int BURST_LENGTH = 8,
    parameter int PERIOD_LOG2  = 7,
    parameter int HOLDOFF      = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            self_triggered_mode,
    input  logic                            trigger_input,
    input  logic                            software_trigger,
    input  logic                            pattern_write_enable,
    input  logic [$clog2(BURST_LENGTH)-1:0] pattern_address,
    input  logic [WIDTH-1:0]                pattern_data,
    output logic [WIDTH-1:0]                word,
    output logic                            sync,
    output logic                            busy,
    output logic [15:0]                     trigger_count,
    output logic [15:0]                     missed_count
);

    localparam int ADDR_W = $clog2(BURST_LENGTH);
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]       word_q, word_d;
    logic                   sync_q, sync_d;
    logic [15:0]            trig_cnt_q, trig_cnt_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic [PERIOD_LOG2-1:0] period_q, period_d;
    logic                   armed_q, armed_d;
    logic                   trig_meta_q, trig_sync1_q, trig_sync2_q;
    logic                   ext_req_q, ext_req_d;
    logic [WIDTH-1:0]       pattern_q [BURST_LENGTH];

    logic periodic_req;
    logic request;
    logic start;

    // NOTE: the table has no reset so it maps onto distributed RAM and survives a
    // scheduler reset; the write is gated so reset still blocks table updates.
    always_ff @(posedge clock) begin
        if (pattern_write_enable && !reset) begin
            pattern_q[pattern_address] <= pattern_data;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        word_d     = '0;
        sync_d     = 1'b0;
        trig_cnt_d = trig_cnt_q;
        miss_cnt_d = miss_cnt_q;
        start      = 1'b0;

        // The periodic counter idles at zero out of reset; arming after its first wrap
        // places the first self-trigger one full period after release.
        period_d     = period_q + 1'b1;
        armed_d      = armed_q | (&period_q);
        periodic_req = armed_q && (period_q == '0);
        // External edge is registered, so a level first sampled at edge k lands at k+3.
        ext_req_d    = trig_sync1_q & ~trig_sync2_q;
        request      = software_trigger | (self_triggered_mode ? periodic_req : ext_req_q);

        case (state_q)
            IDLE: begin
                start = request;
            end
            BURST: begin
                if (idx_q == LAST_IDX) begin
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_W'(HOLDOFF - 1);
                    end
                end else begin
                    idx_d  = idx_q + 1'b1;
                    word_d = pattern_q[idx_q + 1'b1];
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (request && (state_q != IDLE)) begin
`ifdef OSERDES_BURST_SCHEDULER_RETRIGGER_EN
            start = 1'b1;
`else
            miss_cnt_d = (miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
`endif
        end

        if (start) begin
            state_d    = BURST;
            idx_d      = '0;
            word_d     = pattern_q[0];
            sync_d     = 1'b1;
            trig_cnt_d = (trig_cnt_q != 16'hFFFF) ? trig_cnt_q + 16'd1 : trig_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            hold_q       <= '0;
            word_q       <= '0;
            sync_q       <= 1'b0;
            trig_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            period_q     <= '0;
            armed_q      <= 1'b0;
            trig_meta_q  <= 1'b0;
            trig_sync1_q <= 1'b0;
            trig_sync2_q <= 1'b0;
            ext_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            word_q       <= word_d;
            sync_q       <= sync_d;
            trig_cnt_q   <= trig_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            period_q     <= period_d;
            armed_q      <= armed_d;
            trig_meta_q  <= trigger_input;
            trig_sync1_q <= trig_meta_q;
            trig_sync2_q <= trig_sync1_q;
            ext_req_q    <= ext_req_d;
        end
    end

    assign word          = word_q;
    assign sync          = sync_q;
    assign busy          = (state_q != IDLE);
    assign trigger_count = trig_cnt_q;
    assign missed_count  = miss_cnt_q;

endmodule

// File: tb/tb_oserdes_burst_scheduler.sv
// Directed self-checking bench for oserdes_burst_scheduler (default parameters).
// Expectations follow OSERDES_BURST_SCHEDULER_RETRIGGER_EN when it is defined for the build.
module tb_oserdes_burst_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       self_triggered_mode;
    logic       trigger_input;
    logic       software_trigger;
    logic       pattern_write_enable;
    logic [2:0] pattern_address;
    logic [7:0] pattern_data;
    logic [7:0] word;
    logic       sync;
    logic       busy;
    logic [15:0] trigger_count;
    logic [15:0] missed_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_trig = 0;
    int exp_miss = 0;
    logic [7:0] pat [8];

    oserdes_burst_scheduler #(
        .WIDTH(8), .BURST_LENGTH(8), .PERIOD_LOG2(7), .HOLDOFF(4)
    ) dut (
        .clock(clock), .reset(reset), .self_triggered_mode(self_triggered_mode),
        .trigger_input(trigger_input), .software_trigger(software_trigger),
        .pattern_write_enable(pattern_write_enable), .pattern_address(pattern_address),
        .pattern_data(pattern_data), .word(word), .sync(sync), .busy(busy),
        .trigger_count(trigger_count), .missed_count(missed_count)
    );

    always #4 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1; self_triggered_mode = 1'b0; trigger_input = 1'b0;
        software_trigger = 1'b0; pattern_write_enable = 1'b0;
        pattern_address = '0; pattern_data = '0;
        repeat (3) tick();
        n_checks += 5;
        if (word !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h required 00", word); end
        if (sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b required 0", sync); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (trigger_count !== 16'h0) begin n_fail++; $display("FAIL reset_trig: got %h required 0000", trigger_count); end
        if (missed_count !== 16'h0) begin n_fail++; $display("FAIL reset_miss: got %h required 0000", missed_count); end
        reset = 1'b0;
        exp_trig = 0; exp_miss = 0;
        for (int i = 0; i < 8; i++) begin
            pattern_write_enable = 1'b1; pattern_address = 3'(i); pattern_data = pat[i];
            tick();
        end
        pattern_write_enable = 1'b0;
    endtask

    // Checks eight words, sync only on word 0, then the four holdoff cycles.
    task automatic check_burst(input string name);
        for (int i = 0; i < 8; i++) begin
            n_checks += 3;
            if (word !== pat[i]) begin n_fail++; $display("FAIL %s_word%0d: got %h required %h", name, i, word, pat[i]); end
            if (sync !== (i == 0)) begin n_fail++; $display("FAIL %s_sync%0d: got %b required %b", name, i, sync, (i == 0)); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy%0d: got %b required 1", name, i, busy); end
            tick();
        end
        for (int h = 0; h < 4; h++) begin
            n_checks += 2;
            if (word !== 8'h00) begin n_fail++; $display("FAIL %s_hold_word%0d: got %h required 00", name, h, word); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_hold_busy%0d: got %b required 1", name, h, busy); end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_end_busy: got %b required 0", name, busy); end
    endtask

    task automatic test_single_burst();
        repeat (3) tick();
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
        exp_trig++;
        check_burst("single");
        n_checks++;
        if (trigger_count !== 16'(exp_trig)) begin n_fail++; $display("FAIL single_trig: got %0d required %0d", trigger_count, exp_trig); end
    endtask

    task automatic test_external();
        int extra_sync;
        extra_sync = 0;
        self_triggered_mode = 1'b0;
        trigger_input = 1'b1;
        tick(); tick(); tick();
        n_checks += 2;
        if (word !== 8'h00) begin n_fail++; $display("FAIL ext_early_word: got %h required 00 at k+2", word); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ext_early_busy: got %b required 0 at k+2", busy); end
        tick();
        exp_trig++;
        n_checks += 2;
        if (word !== pat[0]) begin n_fail++; $display("FAIL ext_word0: got %h required %h at k+3", word, pat[0]); end
        if (sync !== 1'b1) begin n_fail++; $display("FAIL ext_sync0: got %b required 1 at k+3", sync); end
        for (int i = 0; i < 36; i++) begin tick(); if (sync) extra_sync++; end
        trigger_input = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); if (sync) extra_sync++; end
        n_checks += 2;
        if (extra_sync !== 0) begin n_fail++; $display("FAIL ext_one_burst: got %0d extra bursts required 0", extra_sync); end
        if (trigger_count !== 16'(exp_trig)) begin n_fail++; $display("FAIL ext_trig: got %0d required %0d", trigger_count, exp_trig); end
    endtask

    task automatic test_busy_request();
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
        exp_trig++;
        tick(); tick(); tick();
        n_checks++;
        if (word !== pat[3]) begin n_fail++; $display("FAIL busy_idx3: got %h required %h", word, pat[3]); end
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
`ifdef OSERDES_BURST_SCHEDULER_RETRIGGER_EN
        exp_trig++;
        check_burst("retrig");
`else
        exp_miss++;
        for (int i = 4; i < 8; i++) begin
            n_checks += 2;
            if (word !== pat[i]) begin n_fail++; $display("FAIL drop_word%0d: got %h required %h", i, word, pat[i]); end
            if (sync !== 1'b0) begin n_fail++; $display("FAIL drop_sync%0d: got %b required 0", i, sync); end
            tick();
        end
        wait_idle();
`endif
        n_checks += 2;
        if (trigger_count !== 16'(exp_trig)) begin n_fail++; $display("FAIL busy_trig: got %0d required %0d", trigger_count, exp_trig); end
        if (missed_count !== 16'(exp_miss)) begin n_fail++; $display("FAIL busy_miss: got %0d required %0d", missed_count, exp_miss); end
    endtask

    task automatic test_reset_mid_burst();
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (word !== pat[4]) begin n_fail++; $display("FAIL rst_mid_idx4: got %h required %h", word, pat[4]); end
        reset = 1'b1;
        pattern_write_enable = 1'b1; pattern_address = 3'd0; pattern_data = 8'h77;
        tick();
        reset = 1'b0; pattern_write_enable = 1'b0;
        exp_trig = 0; exp_miss = 0;
        n_checks += 5;
        if (word !== 8'h00) begin n_fail++; $display("FAIL rst_mid_word: got %h required 00", word); end
        if (sync !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sync: got %b required 0", sync); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        if (trigger_count !== 16'h0) begin n_fail++; $display("FAIL rst_mid_trig: got %h required 0000", trigger_count); end
        if (missed_count !== 16'h0) begin n_fail++; $display("FAIL rst_mid_miss: got %h required 0000", missed_count); end
        tick(); tick();
        n_checks++;
        if (word !== 8'h00) begin n_fail++; $display("FAIL rst_mid_quiet: got %h required 00", word); end
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
        exp_trig++;
        check_burst("replay");
    endtask

    task automatic test_same_cycle_write();
        software_trigger = 1'b1;
        pattern_write_enable = 1'b1; pattern_address = 3'd0; pattern_data = 8'h3C;
        tick();
        software_trigger = 1'b0; pattern_write_enable = 1'b0;
        exp_trig++;
        n_checks++;
        if (word !== pat[0]) begin n_fail++; $display("FAIL wr_old_value: got %h required %h", word, pat[0]); end
        pat[0] = 8'h3C;
        wait_idle();
        software_trigger = 1'b1; tick(); software_trigger = 1'b0;
        exp_trig++;
        check_burst("wr_new");
        n_checks++;
        if (trigger_count !== 16'(exp_trig)) begin n_fail++; $display("FAIL wr_trig: got %0d required %0d", trigger_count, exp_trig); end
    endtask

    task automatic test_periodic();
        int n;
        reset = 1'b1; self_triggered_mode = 1'b1; tick(); reset = 1'b0;
        exp_trig = 0; exp_miss = 0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick(); n++; trigger_input = ~trigger_input;
            if (sync) break;
        end
        exp_trig++;
        n_checks += 2;
        if (n !== 129) begin n_fail++; $display("FAIL periodic_first: got %0d cycles required 129", n); end
        if (word !== pat[0]) begin n_fail++; $display("FAIL periodic_word0: got %h required %h", word, pat[0]); end
        for (int b = 0; b < 2; b++) begin
            n = 0;
            for (int i = 0; i < 300; i++) begin
                tick(); n++; trigger_input = ~trigger_input;
                if (sync) break;
            end
            exp_trig++;
            n_checks++;
            if (n !== 128) begin n_fail++; $display("FAIL periodic_gap%0d: got %0d cycles required 128", b, n); end
        end
        trigger_input = 1'b0;
        n_checks += 2;
        if (missed_count !== 16'h0) begin n_fail++; $display("FAIL periodic_miss: got %0d required 0", missed_count); end
        if (trigger_count !== 16'(exp_trig)) begin n_fail++; $display("FAIL periodic_trig: got %0d required %0d", trigger_count, exp_trig); end
    endtask

    task automatic test_saturation();
        bit reached;
        reset = 1'b1; self_triggered_mode = 1'b0; trigger_input = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b0;
        software_trigger = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 80000; i++) begin
            tick();
`ifdef OSERDES_BURST_SCHEDULER_RETRIGGER_EN
            if (trigger_count == 16'hFFFF) begin reached = 1'b1; break; end
`else
            if (missed_count == 16'hFFFF) begin reached = 1'b1; break; end
`endif
        end
        n_checks++;
        if (!reached) begin n_fail++; $display("FAIL sat_timeout: counter never reached FFFF"); end
`ifndef OSERDES_BURST_SCHEDULER_RETRIGGER_EN
        n_checks++;
        if (trigger_count !== 16'd5462) begin n_fail++; $display("FAIL sat_trig_at_full: got %0d required 5462", trigger_count); end
`endif
        repeat (40) tick();
        software_trigger = 1'b0;
        n_checks += 2;
`ifdef OSERDES_BURST_SCHEDULER_RETRIGGER_EN
        if (trigger_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h required FFFF", trigger_count); end
        if (missed_count !== 16'h0) begin n_fail++; $display("FAIL sat_other: got %h required 0000", missed_count); end
`else
        if (missed_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h required FFFF", missed_count); end
        if (trigger_count > 16'd5466 || trigger_count < 16'd5465) begin
            n_fail++; $display("FAIL sat_other: got %0d required 5465..5466", trigger_count);
        end
`endif
    endtask

    initial begin
        pat[0] = 8'hFF; pat[1] = 8'hF3; pat[2] = 8'h99; pat[3] = 8'h80;
        pat[4] = 8'h01; pat[5] = 8'hCC; pat[6] = 8'hAA; pat[7] = 8'h55;
        test_reset();
        test_single_burst();
        test_external();
        test_busy_request();
        test_reset_mid_burst();
        test_same_cycle_write();
        test_periodic();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oserdes_burst_scheduler.md
Name: oserdes_burst_scheduler

Overview:
Sequences the parallel word feeding the 8:1 OSERDES2 trigger-output pair on the 125 MHz fabric clock. Arbitrates three trigger requesters: external LVDS trigger, internal periodic self-trigger and a software pulse. Each accepted request plays one programmable burst of words from a small pattern table, followed by a holdoff. Requests that cannot be serviced are counted as missed.

Parameters:
WIDTH, 8, serializer word width (bits per fabric cycle)
BURST_LENGTH, 8, words per burst; power of 2, 2..16; table depth
PERIOD_LOG2, 7, self-trigger period = 2^PERIOD_LOG2 clock cycles
HOLDOFF, 4, idle cycles forced after each burst; 0 allowed

Ports:
clock  input  1  fabric clock (125 MHz); all logic rising-edge
reset  input  1  synchronous, active-high
self_triggered_mode  input  1  1 = periodic requester enabled, external ignored; 0 = the reverse
trigger_input  input  1  asynchronous external trigger (from IBUFDS)
software_trigger  input  1  single-cycle request, always enabled
pattern_write_enable  input  1  table write strobe
pattern_address  input  log2(BURST_LENGTH)  table write index
pattern_data  input  WIDTH  table write data
word  output  WIDTH  to OSERDES2 D-inputs; MSB serialized first
sync  output  1  high only during burst word 0
busy  output  1  high in BURST or HOLDOFF
trigger_count  output  16  accepted bursts, saturating at 0xFFFF
missed_count  output  16  dropped requests, saturating at 0xFFFF

Behaviour:
- Reset outputs: word=0, sync=0, busy=0, both counters=0. State=IDLE, period counter=0, synchronizer flops=0. Pattern table is not cleared by reset; power-up contents are 0. Table writes are ignored while reset is high.
- Reset mid-burst: word=0 and sync=0 on the cycle after reset is sampled; no further burst words are output.
- External path: 2-flop synchronizer then rising-edge detect (sync1 & ~sync2). One request per rising edge, regardless of pulse width.
- Periodic path: free-running PERIOD_LOG2-bit counter. A request is raised in the cycle the counter equals 0; the first request occurs 2^PERIOD_LOG2 cycles after reset release.
- Combined request = software_trigger | (mode ? periodic : external_edge). Simultaneous requests from several sources count as one request.
- FSM:
  - IDLE: word=0. A request moves the FSM to BURST with index=0.
  - BURST: word=pattern[index], registered; sync=(index==0). index increments each cycle. After the word at index BURST_LENGTH-1 the FSM goes to HOLDOFF, or to IDLE if HOLDOFF=0.
  - HOLDOFF: word=0 for HOLDOFF cycles, then IDLE.
- Latency: software or periodic request in cycle n gives word=pattern[0] and sync=1 in cycle n+1. External: trigger_input first sampled high at edge k gives pattern[0] at edge k+3.
- A request while busy=1 increments missed_count and does not change the burst (overridden by the optional feature). trigger_count increments on the cycle a burst starts.
- Table: 1 write port, 1 read port. Write-then-read to the same address in the same cycle outputs the OLD value. A write takes effect on the following cycle's read, including during a burst.
- Counters saturate and never wrap.

Optional Feature:
OSERDES_BURST_SCHEDULER_RETRIGGER_EN
- Defined: a request during BURST or HOLDOFF restarts the burst at index 0 on the next cycle, with sync=1 again. trigger_count increments; missed_count is unaffected.
- Undefined: such requests are dropped and counted in missed_count as above.

Test Plan:
- Reset release, table loaded with 0xFF,0xF3,0x99,0x80,0x01,0xCC,0xAA,0x55; software_trigger in cycle 10 -> word follows that sequence in cycles 11..18, sync=1 only in cycle 11, busy=1 in cycles 11..22, trigger_count=1.
- self_triggered_mode=1, PERIOD_LOG2=7 -> bursts start exactly every 128 cycles; trigger_input toggling has no effect; missed_count=0.
- self_triggered_mode=0, trigger_input held high 40 cycles, first sampled at edge 100 -> exactly one burst, pattern[0] at edge 103; trigger_count=1.
- software_trigger pulsed at burst index 3 -> retrigger undefined: missed_count=1 and burst completes unchanged; defined: index restarts at 0 on the next cycle with sync=1, trigger_count=2.
- Reset asserted at burst index 4 -> next cycle word=0, sync=0, busy=0, counters=0; table contents retained (next burst replays loaded pattern).
- Force missed_count to 0xFFFF via repeated dropped requests -> value stays at 0xFFFF; same-cycle write to address 0 during index 0 read -> old value output, new value on next burst.
